// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE,
    COIN_CIRCLE,
    COIN_TRIANGLE,
    COIN_PENTAGON
  } coin_t;

  typedef enum logic {
    ACCUM,
    REFUND
  } state_t;

  localparam int VAL_CIRCLE   = 1;
  localparam int VAL_TRIANGLE = 3;
  localparam int VAL_PENTAGON = 5;
  localparam int VAL_W        = 3;

endpackage

// File: rtl/coin_value_decode.sv
// Maps a coin code onto its value in credit units.
module coin_value_decode
  import vend_pkg::*;
(
  input  coin_t            coin,
  output logic [VAL_W-1:0] value
);

  always_comb begin
    value = '0;
    unique case (coin)
      COIN_CIRCLE:   value = VAL_W'(VAL_CIRCLE);
      COIN_TRIANGLE: value = VAL_W'(VAL_TRIANGLE);
      COIN_PENTAGON: value = VAL_W'(VAL_PENTAGON);
      default:       value = '0;
    endcase
  end

endmodule

// File: rtl/vending_credit_fsm.sv
// Coin credit accumulator with multi-vend and unit-pulse refund.
module vending_credit_fsm
  import vend_pkg::*;
#(
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 15,
  parameter int CREDIT_W   = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                refund_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                drop,
  output logic                change,
  output logic                coin_reject,
  output logic                busy
);

  // Wide enough for credit plus the largest coin, whatever CREDIT_W is.
  localparam int SUM_W =
    (CREDIT_W + 1 > VAL_W) ? CREDIT_W + 1 : VAL_W + 1;

  localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_CREDIT);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                drop_n;
  logic                change_n;
  logic                reject_n;
  logic [VAL_W-1:0]    value;
  logic [SUM_W-1:0]    sum;
  logic                coin_in;

  coin_value_decode u_dec (
    .coin  (coin_t'(coin)),
    .value (value)
  );

  assign coin_in = (coin != 2'b00);
  assign busy    = (state == REFUND) | change;

  always_comb begin
    state_n  = state;
    credit_n = credit;
    drop_n   = 1'b0;
    change_n = 1'b0;
    reject_n = 1'b0;
    sum      = SUM_W'(credit) + SUM_W'(value);
    unique case (state)
      ACCUM: begin
        if (refund_req) begin
          reject_n = coin_in;
          if (credit != '0)
            state_n = REFUND;
        end else begin
          if (sum > MAX_S) begin
            reject_n = 1'b1;
            sum      = SUM_W'(credit);
          end
          if (sum >= PRICE_S) begin
            credit_n = CREDIT_W'(sum - PRICE_S);
            drop_n   = 1'b1;
          end else begin
            credit_n = CREDIT_W'(sum);
          end
        end
      end
      REFUND: begin
        change_n = 1'b1;
        reject_n = coin_in;
        credit_n = credit - CREDIT_W'(1);
        if (credit == CREDIT_W'(1))
          state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ACCUM;
      credit      <= '0;
      drop        <= 1'b0;
      change      <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      drop        <= drop_n;
      change      <= change_n;
      coin_reject <= reject_n;
    end
  end

endmodule

// File: tb/tb_vending_credit_fsm.sv
// Scoreboard bench for vending_credit_fsm (default and tight-ceiling builds).
module tb_vending_credit_fsm;

  typedef struct packed {
    logic [3:0] credit;
    logic       drop;
    logic       change;
    logic       rej;
    logic       busy;
  } obs_t;

  typedef struct packed {
    logic [1:0] coin;
    logic       refund;
    logic       rst;
    obs_t       exp;
  } step_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] coin = 2'b00;
  logic       refund_req = 1'b0;

  logic [3:0] credit1, credit2;
  logic       drop1, change1, rej1, busy1;
  logic       drop2, change2, rej2, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  obs_t expq[$];

  always #5 clock = ~clock;

  vending_credit_fsm dut (
    .clock       (clock),
    .reset       (reset),
    .coin        (coin),
    .refund_req  (refund_req),
    .credit      (credit1),
    .drop        (drop1),
    .change      (change1),
    .coin_reject (rej1),
    .busy        (busy1)
  );

  vending_credit_fsm #(.PRICE(12), .MAX_CREDIT(13)) dut2 (
    .clock       (clock),
    .reset       (reset),
    .coin        (coin),
    .refund_req  (refund_req),
    .credit      (credit2),
    .drop        (drop2),
    .change      (change2),
    .coin_reject (rej2),
    .busy        (busy2)
  );

  function automatic obs_t obs1();
    return '{credit1, drop1, change1, rej1, busy1};
  endfunction

  function automatic obs_t obs2();
    return '{credit2, drop2, change2, rej2, busy2};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("credit=%0d drop=%b change=%b reject=%b busy=%b",
                     o.credit, o.drop, o.change, o.rej, o.busy);
  endfunction

  function automatic step_t mk(logic [1:0] c, logic r, logic rs,
                               int cr, logic d, logic ch,
                               logic rj, logic b);
    step_t s;
    s.coin   = c;
    s.refund = r;
    s.rst    = rs;
    s.exp    = '{4'(cr), d, ch, rj, b};
    return s;
  endfunction

  task automatic apply(step_t s);
    @(negedge clock);
    coin       = s.coin;
    refund_req = s.refund;
    reset      = s.rst;
    expq.push_back(s.exp);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    coin       = 2'b00;
    refund_req = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step_t s[$];
    obs_t e, g;
    s.push_back(mk(2'd3, 1'b1, 1'b1, 0, 0, 0, 0, 0));
    s.push_back(mk(2'd0, 1'b0, 1'b1, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
      g = obs2();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset2[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_circles();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd1, 0, 0, 1, 0, 0, 0, 0));
    s.push_back(mk(2'd1, 0, 0, 2, 0, 0, 0, 0));
    s.push_back(mk(2'd1, 0, 0, 3, 0, 0, 0, 0));
    s.push_back(mk(2'd1, 0, 0, 0, 1, 0, 0, 0));
    s.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL circles[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_pentagon();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd3, 0, 0, 1, 1, 0, 0, 0));
    s.push_back(mk(2'd0, 0, 0, 1, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL pentagon[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_multivend();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd2, 0, 0, 3, 0, 0, 0, 0));
    s.push_back(mk(2'd3, 0, 0, 4, 1, 0, 0, 0));
    s.push_back(mk(2'd0, 0, 0, 0, 1, 0, 0, 0));
    s.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL multivend[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_ceiling();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd3, 0, 0, 5, 0, 0, 0, 0));
    s.push_back(mk(2'd3, 0, 0, 10, 0, 0, 0, 0));
    s.push_back(mk(2'd3, 0, 0, 10, 0, 0, 1, 0));
    s.push_back(mk(2'd2, 0, 0, 1, 1, 0, 0, 0));
    s.push_back(mk(2'd0, 0, 0, 1, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs2();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL ceiling[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_refund();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd2, 0, 0, 3, 0, 0, 0, 0));
    s.push_back(mk(2'd2, 1, 0, 3, 0, 0, 1, 1));
    s.push_back(mk(2'd1, 0, 0, 2, 0, 1, 1, 1));
    s.push_back(mk(2'd0, 1, 0, 1, 0, 1, 0, 1));
    s.push_back(mk(2'd0, 0, 0, 0, 0, 1, 0, 1));
    s.push_back(mk(2'd1, 0, 0, 1, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL refund[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_refund_priority();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd2, 0, 0, 3, 0, 0, 0, 0));
    s.push_back(mk(2'd3, 0, 0, 4, 1, 0, 0, 0));
    s.push_back(mk(2'd0, 1, 0, 4, 0, 0, 0, 1));
    s.push_back(mk(2'd0, 0, 0, 3, 0, 1, 0, 1));
    s.push_back(mk(2'd0, 0, 0, 2, 0, 1, 0, 1));
    s.push_back(mk(2'd0, 0, 0, 1, 0, 1, 0, 1));
    s.push_back(mk(2'd0, 0, 0, 0, 0, 1, 0, 1));
    s.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL priority[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_refund_empty();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(2'd1, 1, 0, 0, 0, 0, 1, 0));
    s.push_back(mk(2'd1, 0, 0, 1, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL empty[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid_refund();
    step_t s[$];
    obs_t e, g;
    do_reset();
    s.push_back(mk(2'd2, 0, 0, 3, 0, 0, 0, 0));
    s.push_back(mk(2'd0, 1, 0, 3, 0, 0, 0, 1));
    s.push_back(mk(2'd0, 0, 0, 2, 0, 1, 0, 1));
    s.push_back(mk(2'd0, 0, 1, 0, 0, 0, 0, 0));
    s.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = expq.pop_front();
      g = obs1();
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL midreset[%0d] got %s want %s", i, fmt(g), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_circles();
    test_pentagon();
    test_multivend();
    test_ceiling();
    test_refund();
    test_refund_priority();
    test_refund_empty();
    test_reset_mid_refund();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vending_credit_fsm.md
# vending_credit_fsm

Parametrised successor to the two-bit-coin soda controller. The block accepts one coin per cycle and accumulates credit up to a configurable ceiling. It vends one item per cycle while credit covers the price, and pays back remaining credit as unit change pulses on request. It sits between the coin-slot decoder and the dispenser/change-hopper drivers.

## Interface
- PRICE, 4: item price in credit units; must be ≥1 and ≤ MAX_CREDIT.
- MAX_CREDIT, 15: credit ceiling; a coin that would push the sum above it is rejected.
- CREDIT_W, $clog2(MAX_CREDIT+1): credit register width.
- Coin values are fixed by the package: circle=1, triangle=3, pentagon=5.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- coin  in  2  00 none, 01 circle, 10 triangle, 11 pentagon; sampled every edge.
- refund_req  in  1  level; request return of all current credit.
- credit  out  CREDIT_W  current credit, registered.
- drop  out  1  one-cycle vend pulse per item, registered.
- change  out  1  one-cycle pulse per credit unit returned, registered.
- coin_reject  out  1  one-cycle pulse: the coin sampled on the previous edge was not accepted.
- busy  out  1  refund in progress; equals (state==REFUND) | change.

## Operation
- States: ACCUM, REFUND. Reset puts the block in ACCUM with credit=0, drop=0, change=0, coin_reject=0, so busy=0.
- ACCUM, refund_req=0:
  - v = value(coin), where none gives 0; sum = credit + v, computed at CREDIT_W+1 bits.
  - If sum > MAX_CREDIT, then v is forced to 0, sum = credit, and coin_reject<=1.
  - If sum ≥ PRICE, then credit<=sum−PRICE and drop<=1. Otherwise credit<=sum and drop<=0.
- Multi-vend: leftover credit may still be ≥PRICE. The block vends again on the next edge with no coin needed, one item per edge, until credit < PRICE.
- ACCUM, refund_req=1:
  - Any coin in that cycle is rejected (coin_reject<=1 if coin≠00).
  - drop<=0.
  - If credit>0, go to REFUND with credit unchanged. If credit==0, stay in ACCUM (no-op).
- Refund takes priority over a pending vend: all credit is returned, even if credit ≥ PRICE.
- REFUND, on each edge:
  - change<=1 and credit<=credit−1.
  - When credit==1 (becoming 0), return to ACCUM.
  - Coins are rejected (coin_reject<=1 if coin≠00). refund_req is ignored.
- change<=0 on every edge that is not in REFUND. coin_reject<=0 whenever the coin was accepted or was 00.
- Credit never wraps and never exceeds MAX_CREDIT.

## Timing
- Latency from coin to credit/drop: 1 edge.
- Refund of N units, where refund_req is sampled at edge E:
  - busy is high from after E through the cycle following edge E+N.
  - change is high after edges E+1..E+N, exactly N pulses.
  - credit reads 0 after edge E+N, and the block accepts coins again from edge E+N+1.
- Reset asserted mid-refund: on that edge, all outputs return to their reset values. Undelivered change is discarded and no further change pulses occur.
- Reset has priority over every other input.

## Structure
- Package vend_pkg contains:
  - coin_t enum: COIN_NONE, COIN_CIRCLE, COIN_TRIANGLE, COIN_PENTAGON.
  - state_t enum: ACCUM, REFUND.
  - Localparams VAL_CIRCLE=1, VAL_TRIANGLE=3, VAL_PENTAGON=5.
- One sub-module, coin_value_decode: combinational mapping coin_t → value in credit units. It is shared with the future multi-slot front end.
- The top level holds the state register, the credit register and the output registers. Next-state logic lives in one always_comb; registers are updated in always_ff.

## Test plan
- Defaults; four circle coins on consecutive edges → credit 1,2,3,0; drop high only after the 4th edge.
- Defaults, credit=0; one pentagon → credit=1, drop=1 for one cycle; then coin=00 → drop=0.
- Defaults, credit=3; one pentagon (sum 8) → drop, credit=4; next edge with no coin → drop again, credit=0 (multi-vend).
- PRICE=12, MAX_CREDIT=13, credit=10; pentagon → coin_reject=1, credit stays 10; then triangle → drop, credit=1.
- Defaults, credit=3; refund_req for one cycle while coin=triangle → coin_reject=1; exactly 3 change pulses; credit 2,1,0; busy deasserts after the last pulse; a following circle is accepted.
- Defaults, credit=3 in REFUND; assert reset after the first change pulse → credit=0, change=0, busy=0; no further pulses.
